// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, decoder handshake and redirect.
// master = fetch unit side, slave = memory/decoder/branch-resolve side.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            o_imem_req_valid;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_req_ready;
    logic            i_imem_rsp_valid;
    logic [XLEN-1:0] i_imem_rsp_data;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic            o_valid;
    logic            i_ready;
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;

    modport master (
        output o_imem_req_valid, o_imem_addr, o_instr, o_pc, o_valid,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_ready,
               i_redirect_valid, i_redirect_pc
    );

    modport slave (
        input  o_imem_req_valid, o_imem_addr, o_instr, o_pc, o_valid,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_ready,
               i_redirect_valid, i_redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, in-order response FIFO.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic rsp_valid_i,
    input  logic out_nz_i,
    input  logic push_try_i,
    input  logic full_i
);
    // Memory protocol sanity: no unsolicited responses, no push beyond capacity.
    a_rsp_solicited: assert property (@(posedge clk) disable iff (!rst_n) rsp_valid_i |-> out_nz_i);
    a_no_overflow:   assert property (@(posedge clk) disable iff (!rst_n) push_try_i |-> !full_i);
endmodule

module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  o_perf_fetched,
    output logic [31:0]  o_perf_bubbles
`endif
);
    localparam int unsigned     PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(32'd4);

    logic            run_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [XLEN-1:0] instr_mem_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];

    logic            redir_s;
    logic [XLEN-1:0] redir_pc_s;
    logic [CW:0]     credit_s;
    logic            req_valid_s;
    logic            fire_s;
    logic            rsp_ok_s;
    logic            drop_s;
    logic            push_s;
    logic            valid_s;
    logic            pop_s;

    assign redir_s     = bus.i_redirect_valid;
    assign redir_pc_s  = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
    // Buffered plus in-flight words may never exceed the FIFO, so every response has a slot.
    assign credit_s    = {1'b0, cnt_q} + {1'b0, out_q};
    assign req_valid_s = run_q && (credit_s < {1'b0, DEPTH_C}) && !redir_s;
    assign fire_s      = req_valid_s && bus.i_imem_req_ready;
    assign rsp_ok_s    = bus.i_imem_rsp_valid && (out_q != ZERO_C);
    assign drop_s      = rsp_ok_s && (drop_q != ZERO_C);
    assign push_s      = rsp_ok_s && !drop_s && (cnt_q != DEPTH_C) && !redir_s;
    assign valid_s     = (cnt_q != ZERO_C) && !redir_s;
    assign pop_s       = valid_s && bus.i_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        if (redir_s) begin
            // Everything still in flight becomes stale and is dropped on return.
            fetch_pc_d = redir_pc_s;
            rsp_pc_d   = redir_pc_s;
            out_d      = out_q - CW'(rsp_ok_s);
            drop_d     = out_q - CW'(rsp_ok_s);
            cnt_d      = ZERO_C;
            rd_d       = {PW{1'b0}};
            wr_d       = {PW{1'b0}};
        end else begin
            out_d = out_q + CW'(fire_s) - CW'(rsp_ok_s);
            cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
            if (fire_s) begin
                fetch_pc_d = fetch_pc_q + STEP_C;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (drop_s) begin
                drop_d = drop_q - CW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
            if (push_s) begin
                rsp_pc_d = rsp_pc_q + STEP_C;
                wr_d     = wr_q + PW'(1'b1);
            end else begin
                rsp_pc_d = rsp_pc_q;
                wr_d     = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + PW'(1'b1);
            end else begin
                rd_d = rd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= ZERO_C;
            drop_q     <= ZERO_C;
            cnt_q      <= ZERO_C;
            rd_q       <= {PW{1'b0}};
            wr_q       <= {PW{1'b0}};
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[wr_q] <= bus.i_imem_rsp_data;
            pc_mem_q[wr_q]    <= rsp_pc_q;
        end
    end

    assign bus.o_imem_req_valid = req_valid_s;
    assign bus.o_imem_addr      = fetch_pc_q;
    assign bus.o_valid          = valid_s;
    assign bus.o_instr          = instr_mem_q[rd_q];
    assign bus.o_pc             = pc_mem_q[rd_q];

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    // Decoder-side throughput counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'h0;
            bubbles_q <= 32'h0;
        end else begin
            fetched_q <= fetched_q + 32'(pop_s);
            bubbles_q <= bubbles_q + 32'(bus.i_ready && !valid_s);
        end
    end

    assign o_perf_fetched = fetched_q;
    assign o_perf_bubbles = bubbles_q;
`endif

    fetch_unit_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsp_valid_i (bus.i_imem_rsp_valid),
        .out_nz_i    (out_q != ZERO_C),
        .push_try_i  (rsp_ok_s && !drop_s && !redir_s),
        .full_i      (cnt_q == DEPTH_C)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model, randomized handshakes and redirects.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_fetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_fetched (perf_fetched),
        .o_perf_bubbles (perf_bubbles)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t        pend_q[$];
    logic [63:0] exp_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, last_due = 0, fires = 0, xfers = 0, bubbles = 0;
    int rdy_pct = 100, irdy_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
    logic [31:0] model_fetch = 32'h0;
    bit          stall_prev  = 1'b0;
    logic [31:0] stall_addr  = 32'h0;
    bit          snap_valid  = 1'b0;
    logic [31:0] snap_addr   = 32'h0;
    bit          did_redir   = 1'b0;
    bit          arm_first   = 1'b0;
    logic [31:0] first_pc    = 32'h0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.i_imem_req_ready = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        bus.i_ready          = 1'b0;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; cyc++;
        rst_n = 1'b0;
        idle_inputs();
        pend_q.delete();
        exp_q.delete();
        model_fetch = 32'h0;
        stall_prev  = 1'b0;
        fires       = 0;
        #1;
        chk("rst_o_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_req_valid", 32'(bus.o_imem_req_valid), 32'h0);
        chk("rst_imem_addr", bus.o_imem_addr, 32'h0);
        repeat (3) begin @(posedge clk); #1; cyc++; end
        last_due = cyc;
        rst_n = 1'b1;
    endtask

    // mode: 0 none, 1 forced redirect, 2 redirect only with response+valid, 3 random redirect
    task automatic step(input int mode, input logic [31:0] rpc);
        bit          redir;
        int          lat;
        req_t        r;
        logic [31:0] tgt;
        @(posedge clk); #1; cyc++;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.i_imem_rsp_valid = 1'b1;
            bus.i_imem_rsp_data  = img(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        tgt = rpc;
        case (mode)
            1:       redir = 1'b1;
            2:       redir = bus.i_imem_rsp_valid && bus.o_valid;
            3: begin
                redir = ($urandom_range(99) < redir_pct);
                tgt   = $urandom();
            end
            default: redir = 1'b0;
        endcase
        did_redir            = redir;
        bus.i_imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.i_ready          = ($urandom_range(99) < irdy_pct);
        bus.i_redirect_valid = redir;
        bus.i_redirect_pc    = tgt;
        #1;
        snap_valid = bus.o_valid;
        snap_addr  = bus.o_imem_addr;
        if (redir) begin
            chk("req_valid_in_redirect", 32'(bus.o_imem_req_valid), 32'h0);
            exp_q.delete();
            model_fetch = {tgt[31:2], 2'b00};
            stall_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_req_valid_held", 32'(bus.o_imem_req_valid), 32'h1);
                chk("stall_addr_stable", bus.o_imem_addr, stall_addr);
            end
            if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
                chk("fetch_addr", bus.o_imem_addr, model_fetch);
                lat    = int'($urandom_range(lat_max, lat_min));
                r.addr = bus.o_imem_addr;
                r.due  = cyc + lat;
                if (r.due <= last_due) r.due = last_due + 1;
                last_due = r.due;
                pend_q.push_back(r);
                exp_q.push_back({model_fetch, img(model_fetch)});
                model_fetch = model_fetch + 32'd4;
                fires++;
            end
            stall_prev = bus.o_imem_req_valid && !bus.i_imem_req_ready;
            stall_addr = bus.o_imem_addr;
        end
    endtask

    // Monitor: every presented instruction must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xfers   = 0;
                bubbles = 0;
            end else begin
                if (bus.i_redirect_valid) begin
                    chk("o_valid_in_redirect", 32'(bus.o_valid), 32'h0);
                end else if (bus.o_valid) begin
                    chk("sb_entry_available", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) begin
                        chk("o_pc", bus.o_pc, exp_q[0][63:32]);
                        chk("o_instr", bus.o_instr, exp_q[0][31:0]);
                        if (bus.i_ready) begin
                            if (arm_first) begin
                                first_pc  = bus.o_pc;
                                arm_first = 1'b0;
                            end
                            void'(exp_q.pop_front());
                            xfers++;
                        end
                    end
                end
                if (bus.i_ready && !bus.o_valid) bubbles++;
            end
        end
    end

    initial begin
        int x0;
        int n;
        idle_inputs();
        do_reset();

        // Steady stream, one instruction per cycle once filled
        rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) step(0, 32'h0);
        x0 = xfers;
        repeat (20) step(0, 32'h0);
        chk("t1_throughput", 32'(xfers - x0), 32'd20);

        // Decoder stalled: credit limits requests to FIFO depth
        do_reset();
        irdy_pct = 0;
        repeat (12) step(0, 32'h0);
        chk("t2_requests_issued", 32'(fires), 32'd4);
        chk("t2_head_valid", 32'(snap_valid), 32'h1);
        irdy_pct = 100;
        repeat (20) step(0, 32'h0);

        // Redirect with responses in flight, back-to-back redirects
        lat_min = 3; lat_max = 3;
        n = 0;
        while (pend_q.size() < 2 && n < 20) begin
            step(0, 32'h0);
            n++;
        end
        chk("t3_two_in_flight", 32'(pend_q.size() >= 2), 32'h1);
        step(1, 32'h300);
        step(1, 32'h100);
        first_pc  = 32'hDEAD_BEEF;
        arm_first = 1'b1;
        repeat (20) step(0, 32'h0);
        chk("t3_first_pc_after_redirect", first_pc, 32'h100);

        // Redirect coinciding with a response and a pop
        lat_min = 2; lat_max = 2;
        n = 0;
        did_redir = 1'b0;
        while (!did_redir && n < 40) begin
            step(2, 32'h203);
            n++;
        end
        chk("t4_redirect_hit", 32'(did_redir), 32'h1);
        step(0, 32'h0);
        chk("t4_fifo_empty_next", 32'(snap_valid), 32'h0);
        chk("t4_next_fetch_addr", snap_addr, 32'h200);
        repeat (10) step(0, 32'h0);

        // Random handshakes, latencies and redirects over 1000 instructions
        rdy_pct = 50; irdy_pct = 70; lat_min = 1; lat_max = 3; redir_pct = 2;
        x0 = xfers;
        n = 0;
        while ((xfers - x0) < 1000 && n < 12000) begin
            step(3, 32'h0);
            n++;
        end
        chk("t5_reached_1000", 32'((xfers - x0) >= 1000), 32'h1);

        // Address wrap at the top of the space
        rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        step(1, 32'hFFFF_FFFC);
        step(0, 32'h0);
        step(0, 32'h0);
        chk("t6_wrap_addr", snap_addr, 32'h0);
        repeat (12) step(0, 32'h0);

`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(xfers));
        chk("perf_bubbles", perf_bubbles, 32'(bubbles));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
